// File: rtl/johnson_seq_ctrl.sv
// Johnson (twisted-ring) counter sequencer.
// Runs a programmed number of full ring revolutions and drives a one-hot phase decode.
module johnson_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    localparam int IDX_W = $clog2(2*WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic [CNT_W-1:0]   num_rev,
    output logic [WIDTH-1:0]   jc_out,
    output logic [IDX_W-1:0]   phase_idx,
    output logic [2*WIDTH-1:0] phase,
    output logic [CNT_W-1:0]   rev_cnt,
    output logic               busy,
    output logic               done,
    output logic               aborted
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // The last ring state has only the msb set; stepping out of it closes a revolution.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(1) << (WIDTH-1);

    state_t           state, state_next;
    logic [WIDTH-1:0] jc_next;
    logic [CNT_W-1:0] rev_next;
    logic [CNT_W-1:0] num_lat, num_lat_next;
    logic             aborted_next;

    function automatic int popcount(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        jc_next      = jc_out;
        rev_next     = rev_cnt;
        num_lat_next = num_lat;
        aborted_next = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    rev_next     = '0;
                    num_lat_next = num_rev;
                    jc_next      = '0;
                    state_next   = (num_rev != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next   = IDLE;
                    jc_next      = '0;
                    aborted_next = 1'b1;
                end else if (!hold) begin
                    jc_next = {jc_out[WIDTH-2:0], ~jc_out[WIDTH-1]};
                    if (jc_out == LAST) begin
                        rev_next = rev_cnt + CNT_W'(1);
                        if (rev_next == num_lat) begin
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jc_out  <= '0;
            rev_cnt <= '0;
            num_lat <= '0;
            aborted <= 1'b0;
        end else begin
            jc_out  <= jc_next;
            rev_cnt <= rev_next;
            num_lat <= num_lat_next;
            aborted <= aborted_next;
        end
    end

    // Phase index counts ones on the rising half of the ring and mirrors on the falling half.
    always_comb begin
        int pop;
        int idx;
        pop = popcount(jc_out);
        idx = jc_out[WIDTH-1] ? (2*WIDTH - pop) : pop;
        phase_idx = IDX_W'(idx);
    end

    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign phase = busy ? ((2*WIDTH)'(1) << phase_idx) : '0;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl: stimulus pushes expected run results,
// a negedge monitor pops and compares them whenever done or aborted pulses.
module tb_johnson_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       hold;
    logic [7:0] num_rev;
    logic [3:0] jc_out;
    logic [2:0] phase_idx;
    logic [7:0] phase;
    logic [7:0] rev_cnt;
    logic       busy;
    logic       done;
    logic       aborted;

    typedef struct {
        bit is_abort;
        int rev;
        int busy_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;
    int   busy_cnt;

    logic [3:0] seq [8];

    johnson_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .hold      (hold),
        .num_rev   (num_rev),
        .jc_out    (jc_out),
        .phase_idx (phase_idx),
        .phase     (phase),
        .rev_cnt   (rev_cnt),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit is_abort, input int rev, input int cyc);
        exp_t e;
        e.is_abort    = is_abort;
        e.rev         = rev;
        e.busy_cycles = cyc;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input int n);
        @(posedge clk);
        #1 start = 1'b1;
        num_rev = 8'(n);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: counts busy cycles and scores each done/aborted pulse against the queue.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done || aborted) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_event: got done=%0b aborted=%0b, expected none", done, aborted);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("ev_done",    32'(done),    32'(!e.is_abort));
                    checkOutput("ev_aborted", 32'(aborted), 32'(e.is_abort));
                    checkOutput("ev_rev_cnt", 32'(rev_cnt), 32'(e.rev));
                    checkOutput("ev_busy_len", 32'(busy_cnt), 32'(e.busy_cycles));
                    checkOutput("ev_jc_zero", 32'(jc_out),  32'd0);
                    checkOutput("ev_busy_low", 32'(busy),   32'd0);
                    checkOutput("ev_phase_zero", 32'(phase), 32'd0);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        tests = 0;
        fails = 0;
        busy_cnt = 0;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        hold = 1'b0;
        num_rev = 8'd0;

        #2;
        checkOutput("reset_jc",   32'(jc_out),    32'd0);
        checkOutput("reset_idx",  32'(phase_idx), 32'd0);
        checkOutput("reset_phase", 32'(phase),    32'd0);
        checkOutput("reset_rev",  32'(rev_cnt),   32'd0);
        checkOutput("reset_busy", 32'(busy),      32'd0);
        checkOutput("reset_done", 32'(done),      32'd0);
        checkOutput("reset_abort", 32'(aborted),  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // stop in IDLE must produce no event
        @(posedge clk);
        #1 stop = 1'b1;
        repeat (2) @(posedge clk);
        #1 stop = 1'b0;

        // one revolution, full phase walk
        push_exp(1'b0, 1, 8);
        applyStimulus(1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("walk_jc_%0d", i),    32'(jc_out),    32'(seq[i]));
            checkOutput($sformatf("walk_idx_%0d", i),   32'(phase_idx), 32'(i));
            checkOutput($sformatf("walk_phase_%0d", i), 32'(phase),     32'(1) << i);
            checkOutput($sformatf("walk_busy_%0d", i),  32'(busy),      32'd1);
        end
        wait_drain(20);

        // three revolutions with a 5-cycle hold at phase 5
        push_exp(1'b0, 3, 29);
        applyStimulus(3);
        repeat (5) @(posedge clk);
        #1 hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("hold_jc_%0d", k), 32'(jc_out), 32'h0E);
            @(posedge clk);
        end
        #1 hold = 1'b0;
        wait_drain(60);

        // stop on the 11th busy cycle of a two-revolution run
        push_exp(1'b1, 1, 11);
        applyStimulus(2);
        repeat (10) @(posedge clk);
        #1 stop = 1'b1;
        @(negedge clk);
        checkOutput("prestop_jc",  32'(jc_out),  32'h03);
        checkOutput("prestop_rev", 32'(rev_cnt), 32'd1);
        @(posedge clk);
        #1 stop = 1'b0;
        wait_drain(10);

        // zero revolutions: immediate done
        push_exp(1'b0, 0, 0);
        applyStimulus(0);
        wait_drain(10);

        // start held high: only one run until DONE returns to IDLE
        push_exp(1'b0, 2, 16);
        push_exp(1'b0, 2, 16);
        @(posedge clk);
        #1 start = 1'b1;
        num_rev = 8'd2;
        repeat (19) @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("restart_busy", 32'(busy), 32'd1);
        wait_drain(60);

        // asynchronous reset mid-run
        applyStimulus(2);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("arst_jc",    32'(jc_out),    32'd0);
        checkOutput("arst_idx",   32'(phase_idx), 32'd0);
        checkOutput("arst_phase", 32'(phase),     32'd0);
        checkOutput("arst_rev",   32'(rev_cnt),   32'd0);
        checkOutput("arst_busy",  32'(busy),      32'd0);
        checkOutput("arst_done",  32'(done),      32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        push_exp(1'b0, 1, 8);
        applyStimulus(1);
        wait_drain(20);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
